// File: rtl/bg_pkg.sv
// Shared definitions for the background screen-entry fetch scheduler:
// BG count, default fetches per line and the scheduler state encoding.
package bg_pkg;

    localparam int NUM_BG                 = 4;
    localparam int BG_IDX_W               = 2;
    localparam int TILES_PER_LINE_DEFAULT = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN
    } fetch_state_t;

endpackage

// File: rtl/bg_rr_arbiter.sv
// Round-robin pick among the four BG request lines; the search begins at the
// BG after the last one granted and wraps modulo four.
module bg_rr_arbiter
    import bg_pkg::*;
(
    input  logic [NUM_BG-1:0]   req,
    input  logic [BG_IDX_W-1:0] last_grant,
    output logic [NUM_BG-1:0]   gnt_onehot,
    output logic [BG_IDX_W-1:0] gnt_idx,
    output logic                gnt_valid
);

    logic [BG_IDX_W-1:0] cand [NUM_BG];

    // cand[0] is the highest-priority candidate, cand[NUM_BG-1] wraps to last_grant
    for (genvar gi = 0; gi < NUM_BG; gi++) begin : g_cand
        assign cand[gi] = last_grant + BG_IDX_W'(gi + 1);
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = NUM_BG - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[k];
            end
        end
        gnt_onehot = gnt_valid ? (NUM_BG'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/bg_screen_fetch_sched.sv
// Per-scanline screen-entry fetch scheduler for four backgrounds sharing one
// lookup unit and one VRAM read port. Define BG_ROTATE_EN to forward rotation mode.
module bg_screen_fetch_sched
    import bg_pkg::*;
#(
    parameter int TILES_PER_LINE = TILES_PER_LINE_DEFAULT
) (
    input  logic                   clock,
    input  logic                   rst_b,
    input  logic                   line_start,
    input  logic [NUM_BG-1:0]      bg_en,
    input  logic [NUM_BG-1:0][9:0] bg_x,
    input  logic [NUM_BG-1:0][9:0] bg_y,
    input  logic [NUM_BG-1:0][9:0] bg_hmax,
    input  logic [NUM_BG-1:0][9:0] bg_vmax,
    input  logic [NUM_BG-1:0][1:0] bg_sbb,
    input  logic [NUM_BG-1:0]      bg_rotate,
    output logic [9:0]             lu_x,
    output logic [9:0]             lu_y,
    output logic [9:0]             lu_hmax,
    output logic [9:0]             lu_vmax,
    output logic [1:0]             lu_sbb,
    output logic                   lu_rotate,
    input  logic [15:0]            lu_addr,
    output logic                   vram_req,
    output logic [15:0]            vram_addr,
    input  logic                   vram_gnt,
    input  logic                   vram_rvalid,
    input  logic [15:0]            vram_rdata,
    output logic                   entry_valid,
    output logic [1:0]             entry_bg,
    output logic [5:0]             entry_idx,
    output logic [15:0]            entry_data,
    output logic                   busy,
    output logic                   line_done
);

    localparam logic [5:0] TILES_LIM = 6'(TILES_PER_LINE);

    fetch_state_t        state_reg;
    logic [BG_IDX_W-1:0] last_reg;
    logic [BG_IDX_W-1:0] sel_reg;
    logic [NUM_BG-1:0]   sel_oh_reg;

    logic                en_reg   [NUM_BG];
    logic [9:0]          x_reg    [NUM_BG];
    logic [9:0]          y_reg    [NUM_BG];
    logic [9:0]          hmax_reg [NUM_BG];
    logic [9:0]          vmax_reg [NUM_BG];
    logic [1:0]          sbb_reg  [NUM_BG];
    logic [5:0]          cnt_reg  [NUM_BG];

    logic [NUM_BG-1:0]   elig;
    logic [NUM_BG-1:0]   gnt_onehot;
    logic [BG_IDX_W-1:0] gnt_idx;
    logic                gnt_valid;
    logic                entry_fire;

    assign entry_fire = (state_reg == ST_WAIT) && vram_rvalid;

    // Config snapshot and fetch count per BG; line_start always wins
    for (genvar gi = 0; gi < NUM_BG; gi++) begin : g_bg
        always_ff @(posedge clock or negedge rst_b) begin
            if (!rst_b) begin
                en_reg[gi]   <= 1'b0;
                x_reg[gi]    <= '0;
                y_reg[gi]    <= '0;
                hmax_reg[gi] <= '0;
                vmax_reg[gi] <= '0;
                sbb_reg[gi]  <= '0;
                cnt_reg[gi]  <= '0;
            end else if (line_start) begin
                en_reg[gi]   <= bg_en[gi];
                x_reg[gi]    <= bg_x[gi];
                y_reg[gi]    <= bg_y[gi];
                hmax_reg[gi] <= bg_hmax[gi];
                vmax_reg[gi] <= bg_vmax[gi];
                sbb_reg[gi]  <= bg_sbb[gi];
                cnt_reg[gi]  <= '0;
            end else if (entry_fire && sel_oh_reg[gi]) begin
                cnt_reg[gi]  <= cnt_reg[gi] + 6'd1;
            end
        end

        assign elig[gi] = en_reg[gi] && (cnt_reg[gi] < TILES_LIM);
    end

`ifdef BG_ROTATE_EN
    logic rot_reg [NUM_BG];

    for (genvar gi = 0; gi < NUM_BG; gi++) begin : g_rot
        always_ff @(posedge clock or negedge rst_b) begin
            if (!rst_b) begin
                rot_reg[gi] <= 1'b0;
            end else if (line_start) begin
                rot_reg[gi] <= bg_rotate[gi];
            end
        end
    end
`else
    logic unused_bg_rotate;
    assign unused_bg_rotate = ^bg_rotate;
    assign lu_rotate        = 1'b0;
`endif

    bg_rr_arbiter u_arb (
        .req        (elig),
        .last_grant (last_reg),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    // lu_* are held after ARB, so lu_addr and therefore vram_addr stay stable until grant
    assign vram_addr = vram_req ? lu_addr : 16'h0000;
    assign busy      = (state_reg != ST_IDLE);

    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            state_reg   <= ST_IDLE;
            last_reg    <= 2'd3;
            sel_reg     <= '0;
            sel_oh_reg  <= '0;
            vram_req    <= 1'b0;
            entry_valid <= 1'b0;
            entry_bg    <= '0;
            entry_idx   <= '0;
            entry_data  <= '0;
            line_done   <= 1'b0;
            lu_x        <= '0;
            lu_y        <= '0;
            lu_hmax     <= '0;
            lu_vmax     <= '0;
            lu_sbb      <= '0;
`ifdef BG_ROTATE_EN
            lu_rotate   <= 1'b0;
`endif
        end else begin
            entry_valid <= 1'b0;
            line_done   <= 1'b0;
            if (line_start) begin
                // An in-flight read must still be absorbed before arbitrating again
                last_reg  <= 2'd3;
                vram_req  <= 1'b0;
                state_reg <= ((state_reg == ST_WAIT) || (state_reg == ST_DRAIN)) ? ST_DRAIN : ST_ARB;
            end else begin
                case (state_reg)
                    ST_IDLE: state_reg <= ST_IDLE;
                    ST_ARB: begin
                        if (gnt_valid) begin
                            sel_reg    <= gnt_idx;
                            sel_oh_reg <= gnt_onehot;
                            last_reg   <= gnt_idx;
                            lu_x       <= x_reg[gnt_idx] + 10'({cnt_reg[gnt_idx], 3'b000});
                            lu_y       <= y_reg[gnt_idx];
                            lu_hmax    <= hmax_reg[gnt_idx];
                            lu_vmax    <= vmax_reg[gnt_idx];
                            lu_sbb     <= sbb_reg[gnt_idx];
`ifdef BG_ROTATE_EN
                            lu_rotate  <= rot_reg[gnt_idx];
`endif
                            vram_req   <= 1'b1;
                            state_reg  <= ST_REQ;
                        end else begin
                            line_done  <= 1'b1;
                            state_reg  <= ST_IDLE;
                        end
                    end
                    ST_REQ: begin
                        if (vram_gnt) begin
                            vram_req  <= 1'b0;
                            state_reg <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (vram_rvalid) begin
                            entry_valid <= 1'b1;
                            entry_bg    <= sel_reg;
                            entry_idx   <= cnt_reg[sel_reg];
                            entry_data  <= vram_rdata;
                            state_reg   <= ST_ARB;
                        end
                    end
                    ST_DRAIN: begin
                        if (vram_rvalid) begin
                            state_reg <= ST_ARB;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
